// File: rtl/bshifter_pipe.sv
// bshifter_pipe: pipelined multifunction barrel shifter (rotate, logical shift,
// arithmetic shift, left or right) on a W-bit word. There is one register stage
// per shift-amount bit: stage k applies a shift of 2^k when its amount bit is set.
// Each operand travels down the pipe together with its control fields.
//
// Optional feature macro: BSH_FLAGS_EN
//   defined   -> extra outputs zero (y == 0) and cout (last bit shifted or rotated
//                out), registered alongside y and out_valid.
//   undefined -> those ports and their logic are absent.
//
// Handshake: a transfer happens on a rising clock edge when valid and ready are
// both high. valid and its payload stay stable until taken; ready may depend on
// the downstream ready. Here stall = out_valid & ~out_ready, in_ready = ~stall,
// and every stage advances together when not stalled and holds otherwise.
// Bubbles move down the pipe as valid=0 slots and are never compacted.
module bshifter_pipe #(
    parameter  int W  = 32,
    localparam int AW = $clog2(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [AW-1:0] amt,
    input  logic          lr,
    input  logic [1:0]    op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  y
`ifdef BSH_FLAGS_EN
    ,
    output logic          zero,
    output logic          cout
`endif
);

    // Operation encodings; 2'b01 (logical shift) is the default path with zero fill.
    localparam logic [1:0] OP_ROT  = 2'b00;
    localparam logic [1:0] OP_ASH  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    logic stall;
    logic advance;

    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = advance;

    for (genvar k = 0; k < AW; k++) begin : g_stage
        localparam int           S       = 1 << k;
        // Top S bits set: the sign fill pattern for an arithmetic right shift by S.
        localparam logic [W-1:0] HI_MASK = ~({W{1'b1}} >> S);

        // Stage inputs. amt_i only carries the amount bits still to be applied,
        // with bit 0 being the one this stage consumes.
        logic             v_i;
        logic [W-1:0]     d_i;
        logic [AW-1-k:0]  amt_i;
        logic             lr_i;
        logic [1:0]       op_i;
        logic             fill_i;

        // Stage result before and after the register.
        logic [W-1:0]     d_n;
        logic             v_q;
        logic [W-1:0]     d_q;
`ifdef BSH_FLAGS_EN
        logic             c_i;
        logic             c_n;
        logic             c_q;
`endif

        if (k == 0) begin : g_src
            // First stage takes the operand straight from the input port; the sign
            // bit is sampled here so arithmetic fill follows the original a[W-1].
            assign v_i    = in_valid;
            assign d_i    = a;
            assign amt_i  = amt;
            assign lr_i   = lr;
            assign op_i   = op;
            assign fill_i = a[W-1];
`ifdef BSH_FLAGS_EN
            assign c_i    = 1'b0;
`endif
        end else begin : g_src
            assign v_i    = g_stage[k-1].v_q;
            assign d_i    = g_stage[k-1].d_q;
            assign amt_i  = g_stage[k-1].g_ctl.amt_q;
            assign lr_i   = g_stage[k-1].g_ctl.lr_q;
            assign op_i   = g_stage[k-1].g_ctl.op_q;
            assign fill_i = g_stage[k-1].g_ctl.fill_q;
`ifdef BSH_FLAGS_EN
            assign c_i    = g_stage[k-1].c_q;
`endif
        end

        // Apply a shift of S positions when this stage's amount bit is set.
        always_comb begin
            d_n = d_i;
`ifdef BSH_FLAGS_EN
            c_n = c_i;
`endif
            if (amt_i[0] && (op_i != OP_PASS)) begin
                if (lr_i) begin
                    // Left: arithmetic left is identical to logical left.
                    d_n = d_i << S;
                    if (op_i == OP_ROT) begin
                        d_n = d_n | (d_i >> (W - S));
                    end
`ifdef BSH_FLAGS_EN
                    c_n = d_i[W-S];
`endif
                end else begin
                    d_n = d_i >> S;
                    if (op_i == OP_ROT) begin
                        d_n = d_n | (d_i << (W - S));
                    end else if ((op_i == OP_ASH) && fill_i) begin
                        d_n = d_n | HI_MASK;
                    end
`ifdef BSH_FLAGS_EN
                    c_n = d_i[S-1];
`endif
                end
            end
        end

        // Data/valid register of this stage; holds while the pipe is stalled.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v_q <= 1'b0;
                d_q <= '0;
`ifdef BSH_FLAGS_EN
                c_q <= 1'b0;
`endif
            end else if (advance) begin
                v_q <= v_i;
                d_q <= d_n;
`ifdef BSH_FLAGS_EN
                c_q <= c_n;
`endif
            end
        end

        // Control fields only travel as far as the last stage that needs them.
        if (k < AW - 1) begin : g_ctl
            logic [AW-2-k:0] amt_q;
            logic            lr_q;
            logic [1:0]      op_q;
            logic            fill_q;

            // Carry the remaining amount bits and op controls beside the data.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    amt_q  <= '0;
                    lr_q   <= 1'b0;
                    op_q   <= 2'b00;
                    fill_q <= 1'b0;
                end else if (advance) begin
                    amt_q  <= amt_i[AW-1-k:1];
                    lr_q   <= lr_i;
                    op_q   <= op_i;
                    fill_q <= fill_i;
                end
            end
        end
    end

    // The result comes directly from the last stage register: no path from a to y.
    assign out_valid = g_stage[AW-1].v_q;
    assign y         = g_stage[AW-1].d_q;

`ifdef BSH_FLAGS_EN
    logic zero_q;

    // Zero flag is computed from the last stage's next value so it lines up with y;
    // bubbles always load 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_q <= 1'b0;
        end else if (advance) begin
            zero_q <= g_stage[AW-1].v_i & (g_stage[AW-1].d_n == '0);
        end
    end

    assign zero = zero_q;
    assign cout = g_stage[AW-1].c_q;
`endif

endmodule
